// File: rtl/packet_symbol_packer_pkg.sv
// Shared definitions for the narrow/wide symbol adapters: ratio derivation,
// packer state encoding and the MSB-first slot placement.
package packet_symbol_packer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PACK = 1'b1
  } state_e;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int calc_ew(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Slot 0 (first symbol on the narrow side) occupies the most-significant slice.
  function automatic int slice_index(input int slot, input int ratio);
    return ratio - 1 - slot;
  endfunction

endpackage

// File: rtl/packet_symbol_out_reg.sv
// Output holding register: one wide word plus framing sideband, held stable
// while the consumer stalls.
module packet_symbol_out_reg #(
  parameter int DW = 256,
  parameter int EW = 3
) (
  input  logic          clock_clk,
  input  logic          reset_reset,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          sop_i,
  input  logic          eop_i,
  input  logic [EW-1:0] empty_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          sop_o,
  output logic          eop_o,
  output logic [EW-1:0] empty_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          sop_q;
  logic          eop_q;
  logic [EW-1:0] empty_q;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else if (load_i) begin
      // A load may coincide with the consumer taking the previous word.
      data_q  <= data_i;
      valid_q <= 1'b1;
      sop_q   <= sop_i;
      eop_q   <= eop_i;
      empty_q <= empty_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/packet_symbol_packer.sv
// Narrow-to-wide Avalon-ST packer: gathers RATIO narrow symbols MSB-first
// into one wide word, with sop/eop framing and an empty count on short tails.
module packet_symbol_packer
  import packet_symbol_packer_pkg::*;
#(
  parameter int INPUT_SYMBOL_WIDTH  = 32,
  parameter int OUTPUT_SYMBOL_WIDTH = 256,
  localparam int RATIO = calc_ratio(INPUT_SYMBOL_WIDTH, OUTPUT_SYMBOL_WIDTH),
  localparam int EW    = calc_ew(RATIO)
) (
  input  logic                           clock_clk,
  input  logic                           reset_reset,
  input  logic [INPUT_SYMBOL_WIDTH-1:0]  asi_in0_data,
  input  logic                           asi_in0_valid,
  output logic                           asi_in0_ready,
  input  logic                           asi_in0_startofpacket,
  input  logic                           asi_in0_endofpacket,
  output logic [OUTPUT_SYMBOL_WIDTH-1:0] aso_out0_data,
  output logic                           aso_out0_valid,
  input  logic                           aso_out0_ready,
  output logic                           aso_out0_startofpacket,
  output logic                           aso_out0_endofpacket,
  output logic [EW-1:0]                  aso_out0_empty
);

  typedef logic [RATIO-1:0][INPUT_SYMBOL_WIDTH-1:0] word_t;

  state_e        state_q, state_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  word_t         buf_q, buf_d;

  logic          accept;
  logic          active;
  logic          complete;
  logic [EW-1:0] idx;
  word_t         word;
  logic          word_sop;
  logic [EW-1:0] word_empty;

  assign asi_in0_ready = !aso_out0_valid || aso_out0_ready;
  assign accept        = asi_in0_valid && asi_in0_ready;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      // NOTE: the assembly buffer is plain flops, so it is reset like any other state.
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (asi_in0_startofpacket) state_d = ST_PACK;
      if (active && asi_in0_endofpacket) state_d = ST_IDLE;
    end
  end

  // A sop beat always restarts at slot 0, dropping any unfinished word.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    active     = asi_in0_startofpacket || (state_q == ST_PACK);
    idx        = asi_in0_startofpacket ? '0 : cnt_q;
    complete   = accept && active &&
                 ((idx == EW'(RATIO - 1)) || asi_in0_endofpacket);
    word       = asi_in0_startofpacket ? '0 : buf_q;
    word[EW'(slice_index(int'(idx), RATIO))] = asi_in0_data;
    word_sop   = asi_in0_startofpacket || first_q;
    word_empty = EW'(RATIO - 1) - idx;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    if (accept && active) begin
      if (complete) begin
        buf_d   = '0;
        cnt_d   = '0;
        first_d = 1'b0;
      end else begin
        buf_d   = word;
        cnt_d   = idx + EW'(1);
        first_d = word_sop;
      end
    end
  end

  packet_symbol_out_reg #(
    .DW(OUTPUT_SYMBOL_WIDTH),
    .EW(EW)
  ) u_out_reg (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .load_i      (complete),
    .data_i      (word),
    .sop_i       (word_sop),
    .eop_i       (asi_in0_endofpacket),
    .empty_i     (word_empty),
    .ready_i     (aso_out0_ready),
    .data_o      (aso_out0_data),
    .valid_o     (aso_out0_valid),
    .sop_o       (aso_out0_startofpacket),
    .eop_o       (aso_out0_endofpacket),
    .empty_o     (aso_out0_empty)
  );

endmodule

// File: tb/tb_packet_symbol_packer.sv
// Scoreboard bench for packet_symbol_packer: directed packets push expected
// words; a monitor pops and compares on every output handshake.
module tb_packet_symbol_packer;

  localparam int IW = 32;
  localparam int OW = 256;
  localparam int EW = 3;

  logic          clock_clk = 1'b0;
  logic          reset_reset;
  logic [IW-1:0] asi_in0_data;
  logic          asi_in0_valid;
  logic          asi_in0_ready;
  logic          asi_in0_startofpacket;
  logic          asi_in0_endofpacket;
  logic [OW-1:0] aso_out0_data;
  logic          aso_out0_valid;
  logic          aso_out0_ready;
  logic          aso_out0_startofpacket;
  logic          aso_out0_endofpacket;
  logic [EW-1:0] aso_out0_empty;

  typedef struct {
    logic [OW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [OW-1:0] W_A0 = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [OW-1:0] W_A1 = 256'h00000009_0000000A_0000000B_0000000C_0000000D_0000000E_0000000F_00000010;
  localparam logic [OW-1:0] W_B1 = 256'h00000009_0000000A_0000000B_00000000_00000000_00000000_00000000_00000000;
  localparam logic [OW-1:0] W_C  = 256'hDEADBEEF_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [OW-1:0] W_D0 = 256'h00000101_00000102_00000103_00000104_00000105_00000106_00000107_00000108;
  localparam logic [OW-1:0] W_D1 = 256'h00000109_0000010A_0000010B_0000010C_0000010D_0000010E_0000010F_00000110;
  localparam logic [OW-1:0] W_E  = 256'h00000201_00000202_00000203_00000204_00000205_00000206_00000207_00000208;
  localparam logic [OW-1:0] W_F  = 256'h00000301_00000302_00000303_00000304_00000305_00000306_00000307_00000308;

  packet_symbol_packer dut (
    .clock_clk              (clock_clk),
    .reset_reset            (reset_reset),
    .asi_in0_data           (asi_in0_data),
    .asi_in0_valid          (asi_in0_valid),
    .asi_in0_ready          (asi_in0_ready),
    .asi_in0_startofpacket  (asi_in0_startofpacket),
    .asi_in0_endofpacket    (asi_in0_endofpacket),
    .aso_out0_data          (aso_out0_data),
    .aso_out0_valid         (aso_out0_valid),
    .aso_out0_ready         (aso_out0_ready),
    .aso_out0_startofpacket (aso_out0_startofpacket),
    .aso_out0_endofpacket   (aso_out0_endofpacket),
    .aso_out0_empty         (aso_out0_empty)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive point: 1 time unit after the falling edge.
  task automatic step();
    @(negedge clock_clk);
    #1;
  endtask

  task automatic push(input logic [OW-1:0] d, input logic s, input logic e, input logic [EW-1:0] em);
    exp_t x;
    x.data = d; x.sop = s; x.eop = e; x.empty = em;
    sb_q.push_back(x);
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [IW-1:0] d, input logic s, input logic e);
    logic rdy;
    rdy = 1'b0;
    asi_in0_data          = d;
    asi_in0_startofpacket = s;
    asi_in0_endofpacket   = e;
    asi_in0_valid         = 1'b1;
    for (int n = 0; n < 64 && !rdy; n++) begin
      #3;
      rdy = asi_in0_ready;
      step();
    end
    asi_in0_valid = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance within 64 cycles", d);
    end
  endtask

  // Packet of n beats base, base+1, ...; checks one-cycle latency after each completing beat.
  task automatic send_pkt(input logic [IW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      send(base + IW'(i), i == 0, i == n - 1);
      if ((i % 8) == 7 || i == n - 1) check("latency_valid", 256'(aso_out0_valid), 256'd1);
    end
  endtask

  // Monitor: sampled just before the rising edge at which a handshake would occur.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_clk);
      #3;
      if (!reset_reset && aso_out0_valid && aso_out0_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, required no word", aso_out0_data);
        end else begin
          e = sb_q.pop_front();
          check("word_data", aso_out0_data, e.data);
          check("word_sop", 256'(aso_out0_startofpacket), 256'(e.sop));
          check("word_eop", 256'(aso_out0_endofpacket), 256'(e.eop));
          check("word_empty", 256'(aso_out0_empty), 256'(e.empty));
        end
      end
    end
  end

  initial begin
    reset_reset           = 1'b1;
    asi_in0_data          = '0;
    asi_in0_valid         = 1'b0;
    asi_in0_startofpacket = 1'b0;
    asi_in0_endofpacket   = 1'b0;
    aso_out0_ready        = 1'b1;

    #2;
    check("rst_valid", 256'(aso_out0_valid), 256'd0);
    check("rst_data", aso_out0_data, '0);
    check("rst_sideband", 256'({aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_empty}), 256'd0);
    check("rst_in_ready", 256'(asi_in0_ready), 256'd1);
    step();
    step();
    reset_reset = 1'b0;
    step();
    check("post_rst_in_ready", 256'(asi_in0_ready), 256'd1);

    // Full 16-beat packet.
    push(W_A0, 1'b1, 1'b0, 3'd0);
    push(W_A1, 1'b0, 1'b1, 3'd0);
    send_pkt(32'h1, 16);
    step();

    // Short tail: 11 beats.
    push(W_A0, 1'b1, 1'b0, 3'd0);
    push(W_B1, 1'b0, 1'b1, 3'd5);
    send_pkt(32'h1, 11);
    step();

    // Single beat with sop+eop.
    push(W_C, 1'b1, 1'b1, 3'd7);
    send(32'hDEADBEEF, 1'b1, 1'b1);
    check("single_latency", 256'(aso_out0_valid), 256'd1);
    step();

    // Backpressure: stall after word 0, offer beat 9 during the stall.
    push(W_D0, 1'b1, 1'b0, 3'd0);
    push(W_D1, 1'b0, 1'b1, 3'd0);
    aso_out0_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h101 + IW'(i), i == 0, 1'b0);
    asi_in0_data          = 32'h109;
    asi_in0_startofpacket = 1'b0;
    asi_in0_endofpacket   = 1'b0;
    asi_in0_valid         = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("stall_in_ready", 256'(asi_in0_ready), 256'd0);
      check("stall_valid", 256'(aso_out0_valid), 256'd1);
      check("stall_data", aso_out0_data, W_D0);
      check("stall_sop", 256'(aso_out0_startofpacket), 256'd1);
      step();
    end
    aso_out0_ready = 1'b1;
    for (int i = 8; i < 16; i++) send(32'h101 + IW'(i), 1'b0, i == 15);
    step();

    // Missing eop: stray beats, an abandoned partial packet, then a full one.
    push(W_E, 1'b1, 1'b1, 3'd0);
    send(32'hBAD00001, 1'b0, 1'b0);
    send(32'hBAD00002, 1'b0, 1'b0);
    send(32'h000000A1, 1'b1, 1'b0);
    send(32'h000000A2, 1'b0, 1'b0);
    send(32'h000000A3, 1'b0, 1'b0);
    send_pkt(32'h201, 8);
    step();

    // Asynchronous reset pulse after 5 beats.
    for (int i = 0; i < 5; i++) send(32'hF00 + IW'(i), i == 0, 1'b0);
    reset_reset = 1'b1;
    #1;
    check("arst_valid", 256'(aso_out0_valid), 256'd0);
    check("arst_data", aso_out0_data, '0);
    check("arst_sideband", 256'({aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_empty}), 256'd0);
    check("arst_in_ready", 256'(asi_in0_ready), 256'd1);
    step();
    reset_reset = 1'b0;
    step();
    push(W_F, 1'b1, 1'b1, 3'd0);
    send_pkt(32'h301, 8);

    repeat (4) step();
    check("scoreboard_drain", 256'(sb_q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_symbol_packer.md
# packet_symbol_packer

Narrow-to-wide Avalon-ST packet adapter: gathers OUTPUT_SYMBOL_WIDTH/INPUT_SYMBOL_WIDTH consecutive narrow input symbols into one wide output word. The first narrow symbol of each word lands in the most-significant slice, the inverse of the wide-to-narrow symbol width adapter. It sits on the receive side of a narrow link (32-bit), in front of 256-bit packet consumers. Sideband signals carry packet framing and an empty count for a short final word.

## Interface
- INPUT_SYMBOL_WIDTH, 32, narrow input word width in bits.
- OUTPUT_SYMBOL_WIDTH, 256, wide output word width in bits.
  - Must be an integer multiple ≥2 of INPUT_SYMBOL_WIDTH.
  - RATIO = OUTPUT_SYMBOL_WIDTH/INPUT_SYMBOL_WIDTH.
- Derived: EW = $clog2(RATIO), the empty field width.

Ports:
- clock_clk  in  1  clock.
- reset_reset  in  1  reset, asynchronous, active-high.
- asi_in0_data  in  INPUT_SYMBOL_WIDTH  narrow symbol.
- asi_in0_valid  in  1  input beat valid.
- asi_in0_ready  out  1  input beat accepted when valid&&ready.
- asi_in0_startofpacket  in  1  first beat of packet.
- asi_in0_endofpacket  in  1  last beat of packet.
- aso_out0_data  out  OUTPUT_SYMBOL_WIDTH  packed word.
- aso_out0_valid  out  1  output word valid.
- aso_out0_ready  in  1  downstream accept.
- aso_out0_startofpacket  out  1  first word of packet.
- aso_out0_endofpacket  out  1  last word of packet.
- aso_out0_empty  out  EW  unused narrow slots in the word; nonzero only with endofpacket.

## Operation
- Internal state:
  - Assembly buffer: RATIO slots.
  - Slot counter: 0..RATIO-1.
  - First-word flag.
  - Output register: data, valid, sop, eop, empty.
- State machine:
  - IDLE: beats without sop are accepted and discarded. A beat with sop writes slot 0, sets the first-word flag and moves to PACK.
  - PACK: each accepted beat writes slot[cnt], which occupies bits [(RATIO-cnt)*IN-1 -: IN].
    - If cnt==RATIO-1 or eop, the word completes:
      - The word moves to the output register.
      - sop on the word is the first-word flag, which then clears.
      - The slot counter resets to 0.
    - An eop completion also returns to IDLE.
    - Otherwise cnt increments.
- Short final word:
  - Slots above cnt are zero-filled.
  - empty = RATIO-1-cnt.
- sop+eop on the same beat gives a single word with sop=eop=1 and empty=RATIO-1.
- A sop received in PACK (missing eop) drops the partial word silently. The beat restarts a packet at slot 0 and the first-word flag is set.
- Backpressure:
  - asi_in0_ready = !aso_out0_valid || aso_out0_ready (combinational).
  - No input beat is accepted while a completed word is stalled.
  - The output holds all fields stable while valid && !ready.
- Output register handling:
  - It loads on a completing beat.
  - It clears valid on an accept with no new completion.
  - A simultaneous accept and completion replaces the word with no bubble.

## Timing
- Reset values:
  - aso_out0_valid/sop/eop = 0, data = 0, empty = 0.
  - State IDLE, cnt 0, buffer 0.
  - asi_in0_ready reads 1 during and after reset.
- Latency: an output word is valid on the clock edge following acceptance of its completing input beat.
- Throughput: one input beat per cycle sustained when downstream is always ready, giving one output word per RATIO input cycles.
- Reset mid-packet discards the partial word and any pending output word. The next packet must begin with sop.
- The slot counter never exceeds RATIO-1, so there is no wrap-around beyond the completion rule.

## Structure
- Shared package holds:
  - the RATIO/EW derivation functions;
  - the state encoding constants (IDLE, PACK);
  - the slice-index helper shared with the wide-to-narrow adapter, so the MSB-first ordering is defined once.
- One natural sub-module: packet_symbol_out_reg, the output holding register with the valid/ready handshake and sideband fields. Everything else stays in the top.

## Test plan
- Full packet, RATIO=8, 16 beats 0x00000001..0x00000010:
  - Input: sop on beat 1, eop on beat 16, out_ready=1.
  - Required: two words. Word 0 is 0x00000001_..._00000008 with sop=1. Word 1 is 0x00000009_..._00000010 with eop=1, empty=0.
  - Each word valid 1 cycle after its 8th beat.
- Short tail, 11 beats:
  - Required: word 1 holds beats 9..11 in the top 3 slices and zeros below, with eop=1, empty=5.
- Single beat with sop+eop, data 0xDEADBEEF:
  - Required: one word 0xDEADBEEF followed by 224 zero bits, sop=eop=1, empty=7.
- Backpressure:
  - Stimulus: hold out_ready=0 after word 0 completes.
  - Required: in_ready=0, word 0 stable, no beats lost. Releasing ready gives 16 beats in, 2 words out, in order.
- Missing eop:
  - Stimulus: sop, 3 beats, then a new sop with 8 beats and eop.
  - Required: only the second packet is output (sop=eop=1, empty=0). Stray beats without sop before it are dropped.
- Asynchronous reset pulse mid-packet after 5 beats:
  - Required: outputs are immediately at reset values. A subsequent clean 8-beat packet produces exactly one correct word.
